calc_cmd_sequencer: RTL and testbench

//  Buffers keypad codes in a small FIFO and feeds them one at a time to the calculator core's cmd input.

---
 rtl/calc_cmd_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_calc_cmd_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_cmd_sequencer.sv
// rtl/calc_cmd_sequencer.sv - keypad command FIFO and core-handshake sequencer
//
// Purpose:
//   Queues 4-bit keypad codes in a DEPTH-entry FIFO and issues them one at a
//   time on o_cmd, paced by the calculator core's status handshake
//   (2'b10 ready, 2'b01 busy/refresh, 2'b00 error). At most one command is in
//   flight. A sampled error status parks the block in a sticky ERROR state
//   with the FIFO flushed until reset.
//
// Optional feature macro: CMDSEQ_WDOG_EN
//   When defined, a cycle counter runs in ISSUE/BUSY and forces ERROR once
//   it reaches WDOG_MAX without a state change. When undefined there is no
//   counter and the WDOG_MAX parameter does not exist.
//
// Ports:
//   i_clock       system clock, rising edge
//   i_reset       asynchronous, active-high reset
//   i_key_valid   keypad code present
//   i_key_code    keypad code 0..15
//   o_key_ready   FIFO can accept; push = i_key_valid & o_key_ready
//   i_status      core status (00 err, 01 busy, 10 ready)
//   o_cmd         registered command to the core
//   o_busy        high whenever the sequencer is not IDLE
//   o_err         sticky error flag
//   o_fifo_cnt    current FIFO occupancy
//   o_cmd_count   number of issued commands, wraps at 16'hFFFF -> 0

module calc_cmd_sequencer #(
    parameter int          DEPTH    = 8,
    parameter logic [3:0]  IDLE_CMD = 4'hD
`ifdef CMDSEQ_WDOG_EN
    ,
    parameter int          WDOG_MAX = 64
`endif
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_key_valid,
    input  logic [3:0]               i_key_code,
    output logic                     o_key_ready,
    input  logic [1:0]               i_status,
    output logic [3:0]               o_cmd,
    output logic                     o_busy,
    output logic                     o_err,
    output logic [$clog2(DEPTH):0]   o_fifo_cnt,
    output logic [15:0]              o_cmd_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    localparam logic [1:0] STAT_ERROR = 2'b00;
    localparam logic [1:0] STAT_READY = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    // FIFO storage and bookkeeping
    logic [3:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_cnt;

    // FSM state and registered outputs
    state_t        r_state;
    logic [3:0]    r_cmd;
    logic          r_busy;
    logic          r_err;
    logic [15:0]   r_cmd_count;

    logic          w_ready;
    logic          w_push;
    logic          w_pop;
    logic          w_to_error;
    logic          w_flush;
    logic          w_wdog_hit;
    logic [3:0]    w_head;

    // Ready depends only on registered count and error flag, so a pop in
    // the same cycle never opens the FIFO early when it is full.
    assign w_ready = (r_cnt < FULL_CNT) && !r_err;
    assign w_push  = i_key_valid && w_ready;
    assign w_head  = r_mem[r_rd_ptr];

    // Error entry beats every other transition, including a pop.
    assign w_to_error = (r_state != S_ERROR) &&
                        ((i_status == STAT_ERROR) || w_wdog_hit);

    assign w_pop = (r_state == S_IDLE) && (r_cnt != '0) &&
                   (i_status == STAT_READY) && !w_to_error;

    // Keep the FIFO empty for as long as the block is parked in ERROR.
    assign w_flush = w_to_error || (r_state == S_ERROR);

`ifdef CMDSEQ_WDOG_EN
    localparam int WW = $clog2(WDOG_MAX + 1);

    logic [WW-1:0] r_wdog;
    logic          w_state_change;
    logic          w_wdog_active;

    assign w_wdog_active  = (r_state == S_ISSUE) || (r_state == S_BUSY);

    // Mirrors the transition conditions of the FSM below (excluding the
    // watchdog itself, which only fires when nothing else moved the state).
    assign w_state_change = (i_status == STAT_ERROR) || w_pop ||
                            ((r_state == S_ISSUE) && (i_status != STAT_READY)) ||
                            ((r_state == S_BUSY)  && (i_status == STAT_READY));

    // r_wdog counts completed cycles in the current ISSUE/BUSY stay; it
    // equals WDOG_MAX-1 on the edge that would be the WDOG_MAX-th cycle.
    assign w_wdog_hit = w_wdog_active && !w_state_change &&
                        (r_wdog == WW'(WDOG_MAX - 1));

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_wdog <= '0;
        end else if (w_state_change || !w_wdog_active || w_wdog_hit) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + WW'(1);
        end
    end
`else
    assign w_wdog_hit = 1'b0;
`endif

    // Storage array carries no reset; contents are only meaningful
    // between the read and write pointers.
    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_key_code;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (AW + 1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW + 1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_cmd       <= IDLE_CMD;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_cmd_count <= 16'd0;
        end else if (w_to_error) begin
            r_state <= S_ERROR;
            r_cmd   <= IDLE_CMD;
            r_busy  <= 1'b1;
            r_err   <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state     <= S_ISSUE;
                        r_cmd       <= w_head;
                        r_busy      <= 1'b1;
                        r_cmd_count <= r_cmd_count + 16'd1;
                    end
                end
                S_ISSUE: begin
                    // Command stays on the bus until the core drops ready.
                    if (i_status != STAT_READY) begin
                        r_state <= S_BUSY;
                        r_cmd   <= IDLE_CMD;
                    end
                end
                S_BUSY: begin
                    if (i_status == STAT_READY) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_ERROR: begin
                    r_cmd <= IDLE_CMD;
                end
            endcase
        end
    end

    assign o_key_ready = w_ready;
    assign o_cmd       = r_cmd;
    assign o_busy      = r_busy;
    assign o_err       = r_err;
    assign o_fifo_cnt  = r_cnt;
    assign o_cmd_count = r_cmd_count;

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// tb/tb_calc_cmd_sequencer.sv - scoreboard bench for calc_cmd_sequencer

module tb_calc_cmd_sequencer;

    localparam logic [3:0] IDLE_CMD = 4'hD;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_ready;
    logic [1:0]  status;
    logic [3:0]  cmd;
    logic        busy;
    logic        err;
    logic [3:0]  fifo_cnt;
    logic [15:0] cmd_count;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_q [$];

    always #5 clk = ~clk;

    calc_cmd_sequencer dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_key_valid (key_valid),
        .i_key_code  (key_code),
        .o_key_ready (key_ready),
        .i_status    (status),
        .o_cmd       (cmd),
        .o_busy      (busy),
        .o_err       (err),
        .o_fifo_cnt  (fifo_cnt),
        .o_cmd_count (cmd_count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; key_valid = 1'b0; key_code = 4'd0; status = 2'b01;
        tick; tick;
        checks++; if (cmd !== IDLE_CMD) begin errors++; $display("FAIL reset_cmd got %0h exp %0h", cmd, IDLE_CMD); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b exp 0", err); end
        checks++; if (fifo_cnt !== 4'd0) begin errors++; $display("FAIL reset_fifo_cnt got %0d exp 0", fifo_cnt); end
        checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL reset_key_ready got %0b exp 1", key_ready); end
        checks++; if (cmd_count !== 16'd0) begin errors++; $display("FAIL reset_cmd_count got %0d exp 0", cmd_count); end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_single;
        logic [3:0] e;
        status = 2'b10; key_valid = 1'b1; key_code = 4'd3;
        if (key_valid && key_ready) exp_q.push_back(key_code);
        tick;
        key_valid = 1'b0;
        checks++; if (fifo_cnt !== 4'd1) begin errors++; $display("FAIL single_cnt_after_push got %0d exp 1", fifo_cnt); end
        checks++; if (cmd !== IDLE_CMD) begin errors++; $display("FAIL single_cmd_before_issue got %0h exp %0h", cmd, IDLE_CMD); end
        tick;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL single_issue scoreboard empty, cmd %0h", cmd); end
        else begin e = exp_q.pop_front(); if (cmd !== e) begin errors++; $display("FAIL single_issue got %0h exp %0h", cmd, e); end end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %0b exp 1", busy); end
        checks++; if (cmd_count !== 16'd1) begin errors++; $display("FAIL single_count got %0d exp 1", cmd_count); end
        tick;
        checks++; if (cmd !== 4'd3) begin errors++; $display("FAIL single_hold got %0h exp 3", cmd); end
        status = 2'b01;
        tick;
        checks++; if (cmd !== IDLE_CMD) begin errors++; $display("FAIL single_busy_cmd got %0h exp %0h", cmd, IDLE_CMD); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_state got %0b exp 1", busy); end
        status = 2'b10;
        tick;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_back_idle got %0b exp 0", busy); end
    endtask

    // Core model: after each issue keeps ready 2 more cycles, then busy 8.
    task automatic test_back_to_back;
        logic [3:0]  codes [5];
        logic [3:0]  held;
        logic [3:0]  e;
        logic [15:0] start;
        logic [15:0] prev;
        logic        pushed;
        int push_idx, issued, core_t, cyc;
        codes = '{4'd1, 4'd2, 4'd10, 4'd4, 4'd14};
        held = IDLE_CMD; start = cmd_count; prev = cmd_count;
        push_idx = 0; issued = 0; core_t = 100; cyc = 0;
        while ((issued < 5 || busy) && cyc < 300) begin
            status = (core_t >= 2 && core_t < 10) ? 2'b01 : 2'b10;
            if (push_idx < 5) begin key_valid = 1'b1; key_code = codes[push_idx]; end
            else key_valid = 1'b0;
            pushed = key_valid && key_ready;
            if (pushed) exp_q.push_back(key_code);
            tick;
            cyc++;
            if (pushed) push_idx++;
            if (cmd_count !== prev) begin
                prev = cmd_count;
                issued++;
                checks++;
                if (status !== 2'b10) begin errors++; $display("FAIL b2b_issue_while_not_ready status %0b", status); end
                if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_issue scoreboard empty, cmd %0h", cmd); end
                else begin e = exp_q.pop_front(); if (cmd !== e) begin errors++; $display("FAIL b2b_issue got %0h exp %0h", cmd, e); end end
                held = cmd;
                core_t = 0;
            end else begin
                if (core_t < 100) core_t++;
                if (core_t == 1 || core_t == 2) begin
                    checks++; if (cmd !== held) begin errors++; $display("FAIL b2b_hold got %0h exp %0h", cmd, held); end
                end
                if (core_t == 3) begin
                    checks++; if (cmd !== IDLE_CMD) begin errors++; $display("FAIL b2b_release got %0h exp %0h", cmd, IDLE_CMD); end
                end
            end
        end
        key_valid = 1'b0; status = 2'b10;
        checks++; if (cyc >= 300) begin errors++; $display("FAIL b2b_timeout issued %0d exp 5", issued); end
        checks++; if (cmd_count !== start + 16'd5) begin errors++; $display("FAIL b2b_count got %0d exp %0d", cmd_count, start + 16'd5); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_leftover got %0d exp 0", exp_q.size()); end
    endtask

    task automatic test_fill;
        logic [3:0]  e;
        logic [15:0] prev;
        logic        pushed;
        logic        phase_busy;
        int issued, cyc;
        status = 2'b01;
        for (int i = 0; i < 9; i++) begin
            key_valid = 1'b1; key_code = 4'(i + 3);
            checks++;
            if (key_ready !== (i < 8)) begin errors++; $display("FAIL fill_ready_%0d got %0b exp %0b", i, key_ready, (i < 8)); end
            pushed = key_valid && key_ready;
            if (pushed) exp_q.push_back(key_code);
            tick;
        end
        key_valid = 1'b0;
        checks++; if (fifo_cnt !== 4'd8) begin errors++; $display("FAIL fill_cnt got %0d exp 8", fifo_cnt); end
        status = 2'b10;
        checks++; if (key_ready !== 1'b0) begin errors++; $display("FAIL fill_ready_on_pop got %0b exp 0", key_ready); end
        prev = cmd_count; issued = 0; cyc = 0; phase_busy = 1'b0;
        while (issued < 8 && cyc < 100) begin
            status = phase_busy ? 2'b01 : 2'b10;
            tick;
            cyc++;
            if (cmd_count !== prev) begin
                prev = cmd_count;
                issued++;
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL fill_drain scoreboard empty, cmd %0h", cmd); end
                else begin e = exp_q.pop_front(); if (cmd !== e) begin errors++; $display("FAIL fill_drain got %0h exp %0h", cmd, e); end end
                phase_busy = 1'b1;
            end else begin
                phase_busy = 1'b0;
            end
        end
        checks++; if (issued != 8) begin errors++; $display("FAIL fill_drain_timeout issued %0d exp 8", issued); end
        status = 2'b01; tick;
        status = 2'b10; tick; tick; tick;
        checks++; if (cmd_count !== prev) begin errors++; $display("FAIL fill_ninth_issued got %0d exp %0d", cmd_count, prev); end
        checks++; if (fifo_cnt !== 4'd0) begin errors++; $display("FAIL fill_empty got %0d exp 0", fifo_cnt); end
    endtask

    task automatic test_error;
        logic [3:0]  e;
        logic [15:0] cnt_at_err;
        status = 2'b01;
        for (int i = 0; i < 4; i++) begin
            key_valid = 1'b1; key_code = 4'(4'hA + i);
            if (key_valid && key_ready) exp_q.push_back(key_code);
            tick;
        end
        key_valid = 1'b0;
        status = 2'b10;
        tick;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL err_issue scoreboard empty, cmd %0h", cmd); end
        else begin e = exp_q.pop_front(); if (cmd !== e) begin errors++; $display("FAIL err_issue got %0h exp %0h", cmd, e); end end
        status = 2'b01;
        tick;
        checks++; if (fifo_cnt !== 4'd3) begin errors++; $display("FAIL err_queued got %0d exp 3", fifo_cnt); end
        status = 2'b00;
        tick;
        exp_q.delete();
        cnt_at_err = cmd_count;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_flag got %0b exp 1", err); end
        checks++; if (fifo_cnt !== 4'd0) begin errors++; $display("FAIL err_flush got %0d exp 0", fifo_cnt); end
        checks++; if (cmd !== IDLE_CMD) begin errors++; $display("FAIL err_cmd got %0h exp %0h", cmd, IDLE_CMD); end
        checks++; if (key_ready !== 1'b0) begin errors++; $display("FAIL err_ready got %0b exp 0", key_ready); end
        status = 2'b10; key_valid = 1'b1; key_code = 4'd6;
        tick; tick; tick;
        key_valid = 1'b0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %0b exp 1", err); end
        checks++; if (cmd !== IDLE_CMD || cmd_count !== cnt_at_err) begin errors++; $display("FAIL err_no_issue got cmd %0h count %0d exp %0h %0d", cmd, cmd_count, IDLE_CMD, cnt_at_err); end
        checks++; if (fifo_cnt !== 4'd0) begin errors++; $display("FAIL err_no_store got %0d exp 0", fifo_cnt); end
    endtask

    task automatic test_reset_mid;
        logic [3:0] e;
        rst = 1'b1; tick; rst = 1'b0; tick;
        status = 2'b01;
        for (int i = 0; i < 5; i++) begin
            key_valid = 1'b1; key_code = 4'(i + 1);
            if (key_valid && key_ready) exp_q.push_back(key_code);
            tick;
        end
        key_valid = 1'b0;
        status = 2'b10;
        tick;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rst_issue scoreboard empty, cmd %0h", cmd); end
        else begin e = exp_q.pop_front(); if (cmd !== e) begin errors++; $display("FAIL rst_issue got %0h exp %0h", cmd, e); end end
        checks++; if (fifo_cnt !== 4'd4) begin errors++; $display("FAIL rst_queued got %0d exp 4", fifo_cnt); end
        #2 rst = 1'b1;
        #1;
        exp_q.delete();
        checks++; if (cmd !== IDLE_CMD) begin errors++; $display("FAIL rst_async_cmd got %0h exp %0h", cmd, IDLE_CMD); end
        checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rst_async_flags got busy %0b err %0b exp 0 0", busy, err); end
        checks++; if (fifo_cnt !== 4'd0 || key_ready !== 1'b1) begin errors++; $display("FAIL rst_async_fifo got cnt %0d ready %0b exp 0 1", fifo_cnt, key_ready); end
        checks++; if (cmd_count !== 16'd0) begin errors++; $display("FAIL rst_async_count got %0d exp 0", cmd_count); end
        tick;
        rst = 1'b0;
        key_valid = 1'b1; key_code = 4'd7;
        if (key_valid && key_ready) exp_q.push_back(key_code);
        tick;
        key_valid = 1'b0;
        tick;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rst_after_issue scoreboard empty, cmd %0h", cmd); end
        else begin e = exp_q.pop_front(); if (cmd !== e) begin errors++; $display("FAIL rst_after_issue got %0h exp %0h", cmd, e); end end
        checks++; if (cmd_count !== 16'd1) begin errors++; $display("FAIL rst_after_count got %0d exp 1", cmd_count); end
    endtask

    // Entered with 7 just issued; status held ready so ISSUE never exits.
    task automatic test_watchdog;
        status = 2'b10;
        for (int i = 1; i <= 70; i++) begin
            tick;
`ifdef CMDSEQ_WDOG_EN
            if (i == 63) begin
                checks++; if (err !== 1'b0) begin errors++; $display("FAIL wdog_early got %0b exp 0", err); end
            end
            if (i == 64) begin
                checks++; if (err !== 1'b1) begin errors++; $display("FAIL wdog_fire got %0b exp 1", err); end
                checks++; if (cmd !== IDLE_CMD || fifo_cnt !== 4'd0) begin errors++; $display("FAIL wdog_state got cmd %0h cnt %0d exp %0h 0", cmd, fifo_cnt, IDLE_CMD); end
            end
`else
            if (i == 70) begin
                checks++; if (err !== 1'b0) begin errors++; $display("FAIL wdog_absent got %0b exp 0", err); end
                checks++; if (cmd !== 4'd7 || busy !== 1'b1) begin errors++; $display("FAIL wdog_hold got cmd %0h busy %0b exp 7 1", cmd, busy); end
            end
`endif
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_fill;
        test_error;
        test_reset_mid;
        test_watchdog;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

endmodule
